// File: rtl/riscv_ex_mc.sv
// riscv_ex_mc -- multi-cycle RISC-V execute stage.
//
// Single-cycle integer ALU plus an optional iterative M-extension unit.
// Multiplies use radix-2 shift-add and divides use restoring division; both
// work on operand magnitudes and apply a sign fix-up on the final iteration.
// Every M op takes exactly XLEN edges after accept, whatever the operands.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous kill of the in-flight or accepting operation
//   in_valid   operation presented          in_ready  stage idle, can accept
//   rdi        destination register         a, b      operands
//   shamt      shift amount for shift ops   funct3    operation select
//   invertb    ADD->SUB, SRL->SRA           muldiv    M-extension decode
//   memop      load/store address calc
//   out_valid  one-cycle completion pulse   result    registered result
//   rd         registered destination       memfetch  registered memop
module riscv_ex_mc #(
    parameter int XLEN      = 32,
    parameter int SHAMT_W   = 5,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         rdi,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [2:0]         funct3,
    input  logic               invertb,
    input  logic               muldiv,
    input  logic               memop,
    output logic               out_valid,
    output logic [XLEN-1:0]    result,
    output logic [4:0]         rd,
    output logic               memfetch
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam int         CNT_W   = $clog2(XLEN) + 1;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;      // {partial sum, remaining multiplier}
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     quo_q, quo_d;        // dividend shifts out, quotient shifts in
    logic [XLEN-1:0]     divisor_q, divisor_d;
    logic [XLEN-1:0]     a_q, a_d;            // original dividend, for divide-by-zero
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;        // product / quotient negative
    logic                rneg_q, rneg_d;      // remainder negative
    logic                bzero_q, bzero_d;
    logic [4:0]          rd_pend_q, rd_pend_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          rd_q, rd_d;
    logic                memfetch_q, memfetch_d;
    logic                out_valid_q, out_valid_d;

    logic                accept, md_sel, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag, alu_res, sra_res;
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]   mul_next, mul_fix;
    logic [XLEN-1:0]     div_rem_next, div_quo_next, quo_fix, rem_fix;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd        = rd_q;
    assign memfetch  = memfetch_q;

    // ALU datapath
    always_comb begin
        // Kept as its own statement so the arithmetic shift stays signed.
        sra_res = $signed(a) >>> shamt;
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = invertb ? (a - b) : (a + b);
            3'b001:  alu_res = a << shamt;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100:  alu_res = a ^ b;
            3'b101:  alu_res = invertb ? sra_res : (a >> shamt);
            3'b110:  alu_res = a | b;
            default: alu_res = a & b;
        endcase
    end

    // Operand sign handling at accept time and one iteration of each unit
    always_comb begin
        accept = in_valid & in_ready & ~flush;
        md_sel = MULDIV_EN & muldiv;
        a_sgn  = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        b_sgn  = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
        a_neg  = a_sgn & a[XLEN-1];
        b_neg  = b_sgn & b[XLEN-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;

        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, prod_q[XLEN-1:1]};
        mul_fix  = neg_q ? -mul_next : mul_next;

        div_shift    = {rem_q, quo_q[XLEN-1]};
        div_diff     = div_shift - {1'b0, divisor_q};
        div_rem_next = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        div_quo_next = {quo_q[XLEN-2:0], ~div_diff[XLEN]};
        // Divide by zero is overridden explicitly so the signed sign fix-up
        // cannot disturb the all-ones quotient or the pass-through remainder.
        quo_fix = bzero_q ? '1  : (neg_q  ? -div_quo_next : div_quo_next);
        rem_fix = bzero_q ? a_q : (rneg_q ? -div_rem_next : div_rem_next);
    end

    // Control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        divisor_d   = divisor_q;
        a_d         = a_q;
        op_d        = op_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        bzero_d     = bzero_q;
        rd_pend_d   = rd_pend_q;
        result_d    = result_q;
        rd_d        = rd_q;
        memfetch_d  = memfetch_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (md_sel) begin
                        state_d   = funct3[2] ? ST_DIV : ST_MUL;
                        cnt_d     = CNT_W'(XLEN);
                        op_d      = funct3;
                        rd_pend_d = rdi;
                        neg_d     = a_neg ^ b_neg;
                        rneg_d    = a_neg;
                        bzero_d   = (b == '0);
                        a_d       = a;
                        mcand_d   = a_mag;
                        prod_d    = {{XLEN{1'b0}}, b_mag};
                        quo_d     = a_mag;
                        rem_d     = '0;
                        divisor_d = b_mag;
                    end else begin
                        result_d    = alu_res;
                        rd_d        = rdi;
                        memfetch_d  = memop;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_IDLE;
                    result_d    = (op_q[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
                    rd_d        = rd_pend_q;
                    memfetch_d  = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            ST_DIV: begin
                rem_d = div_rem_next;
                quo_d = div_quo_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_IDLE;
                    result_d    = op_q[1] ? rem_fix : quo_fix;
                    rd_d        = rd_pend_q;
                    memfetch_d  = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over everything, including a completion on this edge.
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            result_d    = result_q;
            rd_d        = rd_q;
            memfetch_d  = memfetch_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            a_q         <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            bzero_q     <= 1'b0;
            rd_pend_q   <= '0;
            result_q    <= '0;
            rd_q        <= '0;
            memfetch_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            a_q         <= a_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            bzero_q     <= bzero_d;
            rd_pend_q   <= rd_pend_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            memfetch_q  <= memfetch_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/riscv_ex_mc.md
Name: riscv_ex_mc

Overview:
Parametrised multi-cycle execute stage for the RISC-V core. It generalises the single-cycle EX stage to XLEN-bit datapaths and adds optional iterative M-extension multiply/divide. A valid/ready input handshake stalls issue while a multiply or divide is in flight, and a synchronous flush kills the in-flight operation. Sits between decode/regfile read and the memory/writeback stage.

Parameters:
XLEN, 32, datapath width in bits (power of two, ≥8)
SHAMT_W, 5, shift-amount width, equal to log2(XLEN)
MULDIV_EN, 1, 1 enables M-extension ops; 0 treats muldiv as 0 (ALU decode)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of in-flight/accepting op
in_valid  input  1  operation presented
in_ready  output  1  stage can accept (high only in IDLE)
rdi  input  5  destination register
a  input  XLEN  operand A
b  input  XLEN  operand B
shamt  input  SHAMT_W  shift amount for shift ops
funct3  input  3  operation select
invertb  input  1  ADD→SUB, SRL→SRA
muldiv  input  1  select M-extension decode of funct3
memop  input  1  op is a load/store address calculation
out_valid  output  1  one-cycle pulse, result/rd valid
result  output  XLEN  registered result
rd  output  5  registered destination
memfetch  output  1  registered memop (ALU path only)

Behaviour:
- Reset (rst=0, async): result=0, rd=0, out_valid=0, memfetch=0, state IDLE, in_ready=1. Reset mid-op aborts it; no out_valid after release.
- States: IDLE, MUL, DIV. Accept = in_valid & in_ready & ~flush.
- ALU decode (muldiv=0): 000 ADD (invertb: a+~b+1), 001 SLL, 010 SLT signed, 011 SLTU, 100 XOR, 101 SRL (invertb: SRA), 110 OR, 111 AND. Shifts use shamt, never b. SLT/SLTU result zero-extended 0/1.
- ALU latency 1: on accept edge, result, rd, memfetch=memop, out_valid=1; state stays IDLE; back-to-back accept every cycle.
- M decode (muldiv=1, MULDIV_EN=1): 000 MUL low, 001 MULH s×s, 010 MULHSU s×u, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. Accept → MUL or DIV, in_ready=0, counter=XLEN.
- MUL: radix-2 shift-add on magnitudes over XLEN edges, sign fixup at end; 2·XLEN product; select low/high half.
- DIV: restoring divide on magnitudes over XLEN edges; quotient sign = sa^sb, remainder sign = sa (signed ops only).
- Fixed latency XLEN edges after accept for every M op, including special cases: divide by zero → quotient all-ones, remainder = a; signed overflow (min / -1) → quotient = min, remainder 0.
- On the XLEN-th edge: result, rd, memfetch=0, out_valid=1; return to IDLE. in_ready high the following cycle.
- out_valid is a single-cycle pulse; result/rd/memfetch hold until the next completion. No downstream backpressure.
- flush=1: in-flight MUL/DIV abandoned, state IDLE next edge, no out_valid. flush with in_valid in IDLE: not accepted, out_valid=0. result/rd hold.
- in_valid while in_ready=0: ignored; source must hold it.

Test Plan:
- Reset: rst=0 mid-stream → result=0, rd=0, out_valid=0, memfetch=0, in_ready=1 immediately, without a clock edge.
- ALU: rdi=4, a=40, b=2, ADD → next edge result=42, rd=4, out_valid pulse. b=5 with invertb → 35. a=0x80000000, shamt=4, SRA → 0xF8000000. SLT -1<1 → 1. SLTU → 0. memop=1 → memfetch=1.
- MUL: a=-3, b=7 → in_ready=0 for 32 cycles, result=0xFFFFFFEB after 32 edges. MULHU 0xFFFFFFFF² → 0xFFFFFFFE. MULH -1×-1 → 0.
- DIV: DIVU 100/7 → 14, REMU → 2. DIV -7/2 → -3, REM → -1. DIV 7/0 → 0xFFFFFFFF, REM → 7. DIV 0x80000000/-1 → 0x80000000, REM → 0. All at 32-edge latency.
- Stall/flush: present an ADD while DIV busy → accepted only after DIV completes, ADD result the next edge. Flush at cycle 10 of DIV → no out_valid, in_ready=1 next cycle, result unchanged.
- Async reset mid-MUL at cycle 5 → outputs zero at once. After release no out_valid; a fresh ADD completes normally.
